// File: rtl/seq_compare_unit.sv
// Multi-cycle magnitude comparator: scans DIGIT bits per cycle from the MSB and
// reports one-hot zero/positive/negative flags. Optional SEQ_COMPARE_EARLY_EXIT_EN.
module seq_compare_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             positive,
    output logic             negative
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_digit
            $error("seq_compare_unit: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             decided_reg, decided_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             zero_reg, zero_next;
    logic             pos_reg, pos_next;
    logic             neg_reg, neg_next;

    logic [DIGIT-1:0] digit_a, digit_b;
    logic [WIDTH-1:0] sign_mask;

    // Operands shift left each scan cycle so the current digit is always on top.
    assign digit_a   = a_reg[WIDTH-1 -: DIGIT];
    assign digit_b   = b_reg[WIDTH-1 -: DIGIT];
    assign sign_mask = {1'b1, {(WIDTH-1){1'b0}}};

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign zero      = zero_reg;
    assign positive  = pos_reg;
    assign negative  = neg_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            decided_reg <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            zero_reg    <= 1'b0;
            pos_reg     <= 1'b0;
            neg_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            decided_reg <= decided_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            zero_reg    <= zero_next;
            pos_reg     <= pos_next;
            neg_reg     <= neg_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        decided_next = decided_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        zero_next    = zero_reg;
        pos_next     = pos_reg;
        neg_next     = neg_reg;

        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    // Flipping the sign bits maps two's-complement order onto unsigned order.
                    a_next       = is_signed ? (a ^ sign_mask) : a;
                    b_next       = is_signed ? (b ^ sign_mask) : b;
                    zero_next    = 1'b0;
                    pos_next     = 1'b0;
                    neg_next     = 1'b0;
                    decided_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = SCAN;
                end
            end
            SCAN: begin
                a_next   = a_reg << DIGIT;
                b_next   = b_reg << DIGIT;
                cnt_next = cnt_reg + CW'(1);
                if (!decided_reg && (digit_a != digit_b)) begin
                    decided_next = 1'b1;
                    pos_next     = (digit_a > digit_b);
                    neg_next     = (digit_a < digit_b);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
                    state_next   = DONE;
`endif
                end
                if (cnt_reg == CW'(N - 1)) begin
                    if (!decided_reg && (digit_a == digit_b)) begin
                        zero_next = 1'b1;
                    end
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_compare_unit.sv
// Self-checking bench for seq_compare_unit (WIDTH=32, DIGIT=4): directed table,
// randomized ops against an arithmetic reference, backpressure and reset corners.
module tb_seq_compare_unit;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             zero, positive, negative;

    int total_checks = 0;
    int pass_checks  = 0;

    seq_compare_unit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .zero(zero), .positive(positive), .negative(negative)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        z;
        logic        p;
        logic        n;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint actual, input longint expected);
        total_checks++;
        if (actual == expected) pass_checks++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Reference: ordering from plain signed/unsigned arithmetic.
    function automatic void ref_flags(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                                      output logic rz, output logic rp, output logic rn);
        if (rs) begin
            rp = ($signed(ra) > $signed(rb));
            rn = ($signed(ra) < $signed(rb));
        end else begin
            rp = (ra > rb);
            rn = (ra < rb);
        end
        rz = (ra == rb);
    endfunction

    function automatic int ref_latency(input logic [31:0] ra, input logic [31:0] rb);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
        logic [31:0] d;
        d = ra ^ rb;
        for (int i = 0; i < N; i++) begin
            if (((d >> (WIDTH - DIGIT * (i + 1))) & 32'hF) != 0) return i + 1;
        end
`endif
        return N;
    endfunction

    task automatic start_op(input logic [31:0] va, input logic [31:0] vb, input logic vs);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = va; b = vb; is_signed = vs; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    // Full transaction with out_ready held high.
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                          input logic ez, input logic ep, input logic en);
        int lat;
        start_op(va, vb, vs);
        wait_done(lat);
        $display("op a=%08h b=%08h signed=%0d lat=%0d z=%0d p=%0d n=%0d",
                 va, vb, vs, lat, zero, positive, negative);
        check("latency", lat, ref_latency(va, vb));
        check("zero", zero, ez);
        check("positive", positive, ep);
        check("negative", negative, en);
        check("in_ready_in_done", in_ready, 0);
        @(posedge clk);
        #1;
        check("out_valid_after_handshake", out_valid, 0);
        check("in_ready_after_handshake", in_ready, 1);
        check("flags_hold", {zero, positive, negative}, {ez, ep, en});
    endtask

    initial begin
        logic rz, rp, rn;
        logic [31:0] ra, rb;
        logic rs;
        int lat;

        vecs[0] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h10000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_flags", {zero, positive, negative}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].z, vecs[i].p, vecs[i].n);
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = $urandom;
                default: rb = ra ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, 7)));
            endcase
            rs = 1'($urandom_range(0, 1));
            ref_flags(ra, rb, rs, rz, rp, rn);
            run_op(ra, rb, rs, rz, rp, rn);
        end

        // Backpressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        start_op(32'h10, 32'h20, 1'b0);
        wait_done(lat);
        $display("op a=00000010 b=00000020 signed=0 lat=%0d backpressure", lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k == 2);
            a = 32'h1; b = 32'h0;
            check("bp_out_valid", out_valid, 1);
            check("bp_negative", {zero, positive, negative}, 3'b001);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_flags", {zero, positive, negative}, 3'b001);

        // Reset during the third scan cycle drops the operation.
        start_op(32'h12345678, 32'h12345679, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("op a=12345678 b=12345679 signed=0 reset mid-scan");
        check("midreset_out_valid", out_valid, 0);
        check("midreset_flags", {zero, positive, negative}, 0);
        check("midreset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("midreset_no_result", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
